we_frame_arb: RTL and testbench

//  2:1 frame-granular arbiter that shares the single we_top Avalon-ST sink between two

---
 rtl/we_frame_arb.sv | 266 ++++++++++++++++++++++++++
 tb/tb_we_frame_arb.sv | 388 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/we_frame_arb.sv
// ---------------------------------------------------------------------------
// we_frame_arb
//
// Frame-granular 2:1 round-robin arbiter that shares one Avalon-ST sink
// (the we_top sink_* port) between two video sources.
//
// Ownership rules:
//   * A source wins the port in IDLE by presenting a valid sop beat. The sop
//     beat itself is not accepted in IDLE, so every frame costs one bubble.
//   * The owner keeps the port until its eop beat transfers.
//   * When both sources request, the source that was not served last wins.
//     After reset, source 0 wins the first tie.
//   * In IDLE, non-sop beats are drained and discarded so a source that lost
//     frame alignment can resynchronise on its next sop.
//   * While a source owns the port, the datapath is a zero-latency
//     combinational pass-through and the owner's ready is m_ready.
//
// Optional feature (macro FRAME_LEN_CHECK_EN):
//   Counts beats of the owned frame against L = W*H+1 (header + pixels).
//   An eop at any other beat count raises err_len. A frame that reaches L
//   beats without eop gets m_eop forced on beat L, the port is released, and
//   err_len pulses; the remainder of that frame is drained in IDLE. Without
//   the macro there is no length check and err_len is tied low.
//
// Parameters:
//   DW     data width of every stream port
//   W, H   active pixels per line / active lines per frame
//   CNT_W  beat counter width; must hold W*H+1
//
// Ports:
//   clk, rst                      clock, synchronous active-low reset
//   s0_* / s1_*                   source streams (data, valid, sop, eop, ready)
//   m_*                           merged stream towards we_top (ready is input)
//   grant                         one-hot current owner, 2'b00 when idle
//   frame_done                    1-cycle pulse after an eop beat transfers
//   drop                          1-cycle pulse after any beat discarded in IDLE
//   err_len                       1-cycle pulse after a frame-length error
//
// While rst is low every output is held low.
// ---------------------------------------------------------------------------
module we_frame_arb #(
  parameter int DW    = 8,
  parameter int W     = 1920,
  parameter int H     = 1080,
  parameter int CNT_W = 32
) (
  input  logic          clk,
  input  logic          rst,

  input  logic [DW-1:0] s0_data,
  input  logic          s0_valid,
  input  logic          s0_sop,
  input  logic          s0_eop,
  output logic          s0_ready,

  input  logic [DW-1:0] s1_data,
  input  logic          s1_valid,
  input  logic          s1_sop,
  input  logic          s1_eop,
  output logic          s1_ready,

  output logic [DW-1:0] m_data,
  output logic          m_valid,
  output logic          m_sop,
  output logic          m_eop,
  input  logic          m_ready,

  output logic [1:0]    grant,
  output logic          frame_done,
  output logic          drop,
  output logic          err_len
);

  // Elaboration-time guard: the beat counter must be able to reach W*H+1.
  if (((64'(W) * 64'(H) + 64'd1) >> CNT_W) != 64'd0) begin : g_cnt_w_too_small
    $error("we_frame_arb: CNT_W cannot hold W*H+1");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } state_e;

  state_e state_q, state_d;

  // Source served most recently; the other source wins the next tie.
  logic last_q, last_d;

  // Pre-reset-gating versions of the outputs.
  logic [DW-1:0] data_int;
  logic          mv_int;
  logic          sop_int;
  logic          src_eop;
  logic          eop_int;
  logic          s0_rdy_int;
  logic          s1_rdy_int;
  logic [1:0]    grant_int;

  logic req0, req1;
  logic xfer;
  logic frame_end;
  logic idle_discard;

  logic frame_done_q;
  logic drop_q;

  assign req0 = s0_valid & s0_sop;
  assign req1 = s1_valid & s1_sop;

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  // NOTE: every signal driven by an always_comb block gets a default first;
  // a path that leaves one unassigned would infer a latch.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    unique case (state_q)
      ST_IDLE: begin
        // A tie goes to the source that was not served last.
        if (req0 && (!req1 || last_q)) begin
          state_d = ST_OWN0;
        end else if (req1) begin
          state_d = ST_OWN1;
        end
      end
      ST_OWN0: begin
        if (frame_end) begin
          state_d = ST_IDLE;
          last_d  = 1'b0;
        end
      end
      ST_OWN1: begin
        if (frame_end) begin
          state_d = ST_IDLE;
          last_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Output logic: pass-through mux and ready steering
  // -------------------------------------------------------------------------
  always_comb begin
    data_int   = '0;
    mv_int     = 1'b0;
    sop_int    = 1'b0;
    src_eop    = 1'b0;
    s0_rdy_int = 1'b0;
    s1_rdy_int = 1'b0;
    grant_int  = 2'b00;
    unique case (state_q)
      ST_IDLE: begin
        // Drain stray non-sop beats; hold sop beats until a grant exists.
        s0_rdy_int = s0_valid & ~s0_sop;
        s1_rdy_int = s1_valid & ~s1_sop;
      end
      ST_OWN0: begin
        data_int   = s0_data;
        mv_int     = s0_valid;
        sop_int    = s0_sop;
        src_eop    = s0_eop;
        s0_rdy_int = m_ready;
        grant_int  = 2'b01;
      end
      ST_OWN1: begin
        data_int   = s1_data;
        mv_int     = s1_valid;
        sop_int    = s1_sop;
        src_eop    = s1_eop;
        s1_rdy_int = m_ready;
        grant_int  = 2'b10;
      end
      default: ;
    endcase
  end

  assign xfer         = mv_int & m_ready;
  assign frame_end    = xfer & eop_int;
  assign idle_discard = (state_q == ST_IDLE) &&
                        ((s0_valid && !s0_sop) || (s1_valid && !s1_sop));

`ifdef FRAME_LEN_CHECK_EN
  localparam logic [CNT_W-1:0] FRAME_LEN = CNT_W'(W * H + 1);

  // Beats of the current frame already transferred; beat_num is the 1-based
  // position of the beat now on the bus, so the first (sop) transfer loads 1.
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] beat_num;
  logic             len_hit;
  logic             err_len_q;

  assign beat_num = cnt_q + CNT_W'(1);
  assign len_hit  = (state_q != ST_IDLE) && (beat_num == FRAME_LEN);
  // Beat L closes the frame even if the source did not mark it.
  assign eop_int  = src_eop | len_hit;

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q     <= '0;
      err_len_q <= 1'b0;
    end else begin
      if (frame_end) begin
        cnt_q <= '0;
      end else if (xfer) begin
        cnt_q <= beat_num;
      end
      // Error when the frame closes at the wrong length, or closes at L only
      // because the eop was forced.
      err_len_q <= frame_end && ((beat_num != FRAME_LEN) || !src_eop);
    end
  end

  assign err_len = rst & err_len_q;
`else
  assign eop_int = src_eop;
  assign err_len = 1'b0;
`endif

  // -------------------------------------------------------------------------
  // Event pulses, registered so each lands one cycle after its cause.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      frame_done_q <= 1'b0;
      drop_q       <= 1'b0;
    end else begin
      frame_done_q <= frame_end;
      // Both sources discarding in the same cycle still yields one pulse.
      drop_q       <= idle_discard;
    end
  end

  // -------------------------------------------------------------------------
  // Output gating: reset forces every output low immediately, including the
  // cycle in which rst is first sampled.
  // -------------------------------------------------------------------------
  assign m_data     = rst ? data_int : '0;
  assign m_valid    = rst & mv_int;
  assign m_sop      = rst & sop_int;
  assign m_eop      = rst & eop_int;
  assign s0_ready   = rst & s0_rdy_int;
  assign s1_ready   = rst & s1_rdy_int;
  assign grant      = rst ? grant_int : 2'b00;
  assign frame_done = rst & frame_done_q;
  assign drop       = rst & drop_q;

endmodule

// File: tb/tb_we_frame_arb.sv
// ---------------------------------------------------------------------------
// Testbench for we_frame_arb (W=4, H=2, so L=9 beats per frame).
// Inputs are driven 1 time unit after each rising edge; outputs are sampled
// 3 units after the edge, well before the next one.
// ---------------------------------------------------------------------------
module tb_we_frame_arb;

  localparam int DW    = 8;
  localparam int W     = 4;
  localparam int H     = 2;
  localparam int CNT_W = 32;
  localparam int L     = W * H + 1;

`ifdef FRAME_LEN_CHECK_EN
  localparam bit LEN_CHK = 1'b1;
`else
  localparam bit LEN_CHK = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] s0_data, s1_data, m_data;
  logic          s0_valid, s0_sop, s0_eop, s0_ready;
  logic          s1_valid, s1_sop, s1_eop, s1_ready;
  logic          m_valid, m_sop, m_eop, m_ready;
  logic [1:0]    grant;
  logic          frame_done, drop, err_len;

  always #5 clk = ~clk;

  we_frame_arb #(.DW(DW), .W(W), .H(H), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .s0_data    (s0_data),
    .s0_valid   (s0_valid),
    .s0_sop     (s0_sop),
    .s0_eop     (s0_eop),
    .s0_ready   (s0_ready),
    .s1_data    (s1_data),
    .s1_valid   (s1_valid),
    .s1_sop     (s1_sop),
    .s1_eop     (s1_eop),
    .s1_ready   (s1_ready),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_sop      (m_sop),
    .m_eop      (m_eop),
    .m_ready    (m_ready),
    .grant      (grant),
    .frame_done (frame_done),
    .drop       (drop),
    .err_len    (err_len)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic idle_inputs();
    s0_valid = 1'b0; s0_sop = 1'b0; s0_eop = 1'b0; s0_data = '0;
    s1_valid = 1'b0; s1_sop = 1'b0; s1_eop = 1'b0; s1_data = '0;
    m_ready  = 1'b1;
  endtask

  // ------------------------------------------------------------------------
  // Directed vectors: one record per clock cycle.
  // ------------------------------------------------------------------------
  typedef struct {
    logic          rst;
    logic          s0v, s0s, s0e;
    logic [DW-1:0] s0d;
    logic          s1v, s1s, s1e;
    logic [DW-1:0] s1d;
    logic          mr;
    logic          e_mv, e_ms, e_me;
    logic [DW-1:0] e_md;
    logic          e_s0r, e_s1r;
    logic [1:0]    e_gr;
    logic          e_fd, e_dr;
  } vec_t;

  vec_t vecs[11];

  typedef struct packed {
    logic [DW-1:0] d;
    logic          sop;
    logic          eop;
  } beat_t;

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    idle_inputs();
    rst = 1'b0;

    //            rst s0 v s e  d      s1 v s e  d      mr  mv ms me md     s0r s1r gr    fd dr
    vecs[0]  = '{1'b0, 1,1,0, 8'hA1,  1,1,0, 8'hB1,  1,  0,0,0, 8'h00,  0,0, 2'b00, 0,0};
    vecs[1]  = '{1'b1, 1,1,0, 8'hA1,  1,1,0, 8'hB1,  1,  0,0,0, 8'h00,  0,0, 2'b00, 0,0};
    vecs[2]  = '{1'b1, 1,1,1, 8'hA1,  1,1,0, 8'hB1,  1,  1,1,1, 8'hA1,  1,0, 2'b01, 0,0};
    vecs[3]  = '{1'b1, 1,1,0, 8'hA2,  1,1,1, 8'hB1,  1,  0,0,0, 8'h00,  0,0, 2'b00, 1,0};
    vecs[4]  = '{1'b1, 1,1,0, 8'hA2,  1,1,1, 8'hB1,  0,  1,1,1, 8'hB1,  0,0, 2'b10, 0,0};
    vecs[5]  = '{1'b1, 1,1,0, 8'hA2,  1,1,1, 8'hB1,  1,  1,1,1, 8'hB1,  0,1, 2'b10, 0,0};
    vecs[6]  = '{1'b1, 1,1,1, 8'hA2,  1,0,0, 8'hB2,  1,  0,0,0, 8'h00,  0,1, 2'b00, 1,0};
    vecs[7]  = '{1'b1, 1,1,1, 8'hA2,  1,0,0, 8'hB3,  1,  1,1,1, 8'hA2,  1,0, 2'b01, 0,1};
    vecs[8]  = '{1'b1, 1,0,0, 8'hA3,  1,0,0, 8'hB4,  1,  0,0,0, 8'h00,  1,1, 2'b00, 1,0};
    vecs[9]  = '{1'b1, 0,0,0, 8'h00,  0,0,0, 8'h00,  1,  0,0,0, 8'h00,  0,0, 2'b00, 0,1};
    vecs[10] = '{1'b1, 0,0,0, 8'h00,  0,0,0, 8'h00,  1,  0,0,0, 8'h00,  0,0, 2'b00, 0,0};

    for (int i = 0; i < 11; i++) begin
      rst      = vecs[i].rst;
      s0_valid = vecs[i].s0v; s0_sop = vecs[i].s0s; s0_eop = vecs[i].s0e; s0_data = vecs[i].s0d;
      s1_valid = vecs[i].s1v; s1_sop = vecs[i].s1s; s1_eop = vecs[i].s1e; s1_data = vecs[i].s1d;
      m_ready  = vecs[i].mr;
      settle();
      check($sformatf("vec%0d_m_valid", i),    m_valid,    vecs[i].e_mv);
      check($sformatf("vec%0d_s0_ready", i),   s0_ready,   vecs[i].e_s0r);
      check($sformatf("vec%0d_s1_ready", i),   s1_ready,   vecs[i].e_s1r);
      check($sformatf("vec%0d_grant", i),      grant,      vecs[i].e_gr);
      check($sformatf("vec%0d_frame_done", i), frame_done, vecs[i].e_fd);
      check($sformatf("vec%0d_drop", i),       drop,       vecs[i].e_dr);
      if (vecs[i].e_mv) begin
        check($sformatf("vec%0d_m_beat", i), {m_data, m_sop, m_eop},
              {vecs[i].e_md, vecs[i].e_ms, vecs[i].e_me});
      end
      tick();
    end

    // ---- s0 alone streams one well-formed frame with m_ready held high ----
    idle_inputs();
    s0_valid = 1'b1; s0_sop = 1'b1; s0_data = 8'h10;
    settle();
    check("single_bubble_m_valid", m_valid, 1'b0);
    check("single_bubble_s0_ready", s0_ready, 1'b0);
    check("single_bubble_grant", grant, 2'b00);
    tick();
    for (int b = 0; b < L; b++) begin
      s0_data = 8'h10 + 8'(b);
      s0_sop  = (b == 0);
      s0_eop  = (b == L - 1);
      settle();
      check($sformatf("single_grant_b%0d", b), grant, 2'b01);
      check($sformatf("single_beat_b%0d", b), {m_valid, m_data, m_sop, m_eop},
            {1'b1, 8'h10 + 8'(b), b == 0, b == L - 1});
      check($sformatf("single_s0_ready_b%0d", b), s0_ready, 1'b1);
      check($sformatf("single_drop_b%0d", b), drop, 1'b0);
      tick();
    end
    idle_inputs();
    settle();
    check("single_frame_done", frame_done, 1'b1);
    check("single_grant_released", grant, 2'b00);
    check("single_no_err_len", err_len, 1'b0);
    tick();
    settle();
    check("single_frame_done_one_cycle", frame_done, 1'b0);

    // ---- backpressure: m_ready alternates 1,0 during an s0 frame ----
    begin
      int b     = 0;
      int cyc   = 0;
      int xfers = 0;
      s0_valid = 1'b1; s0_sop = 1'b1; s0_data = 8'h20;
      tick();
      while (b < L && cyc < 40) begin
        s0_data = 8'h20 + 8'(b);
        s0_sop  = (b == 0);
        s0_eop  = (b == L - 1);
        m_ready = (cyc % 2 == 0);
        settle();
        check($sformatf("bp_s0_ready_c%0d", cyc), s0_ready, m_ready);
        check($sformatf("bp_grant_c%0d", cyc), grant, 2'b01);
        check($sformatf("bp_beat_c%0d", cyc), {m_valid, m_data, m_eop},
              {1'b1, 8'h20 + 8'(b), b == L - 1});
        if (m_valid && m_ready) xfers++;
        if (m_ready) b++;
        cyc++;
        tick();
      end
      check("bp_xfer_count", xfers, L);
      idle_inputs();
      settle();
      check("bp_frame_done", frame_done, 1'b1);
      tick();
    end

    // ---- s1 sends three stray beats in IDLE, then a frame ----
    for (int j = 0; j < 3; j++) begin
      s1_valid = 1'b1; s1_sop = 1'b0; s1_data = 8'h30 + 8'(j);
      settle();
      check($sformatf("stray%0d_s1_ready", j), s1_ready, 1'b1);
      check($sformatf("stray%0d_m_valid", j), m_valid, 1'b0);
      check($sformatf("stray%0d_drop", j), drop, j > 0);
      tick();
    end
    s1_sop = 1'b1; s1_data = 8'h40;
    settle();
    check("stray_last_drop", drop, 1'b1);
    check("stray_sop_held", s1_ready, 1'b0);
    tick();
    for (int b = 0; b < L; b++) begin
      s1_data = 8'h40 + 8'(b);
      s1_sop  = (b == 0);
      s1_eop  = (b == L - 1);
      settle();
      check($sformatf("s1frame_grant_b%0d", b), grant, 2'b10);
      check($sformatf("s1frame_beat_b%0d", b), {m_valid, m_data, s1_ready, s0_ready},
            {1'b1, 8'h40 + 8'(b), 1'b1, 1'b0});
      tick();
    end
    idle_inputs();
    settle();
    check("s1frame_done", frame_done, 1'b1);
    check("s1frame_no_drop", drop, 1'b0);
    tick();

    // ---- reset asserted on beat 5 of an s1 frame ----
    s1_valid = 1'b1; s1_sop = 1'b1; s1_data = 8'h50;
    tick();
    for (int b = 0; b < 4; b++) begin
      s1_data = 8'h50 + 8'(b);
      s1_sop  = (b == 0);
      tick();
    end
    s1_data = 8'h54;
    rst     = 1'b0;
    settle();
    check("midrst_forced_m_valid", m_valid, 1'b0);
    check("midrst_forced_s1_ready", s1_ready, 1'b0);
    tick();
    rst = 1'b1;
    idle_inputs();
    settle();
    check("midrst_grant", grant, 2'b00);
    check("midrst_m_valid", m_valid, 1'b0);
    check("midrst_no_frame_done", frame_done, 1'b0);
    tick();
    s0_valid = 1'b1; s0_sop = 1'b1; s0_data = 8'h60;
    s1_valid = 1'b1; s1_sop = 1'b1; s1_data = 8'h61;
    tick();
    settle();
    check("midrst_s0_wins", grant, 2'b01);
    check("midrst_s0_data", m_data, 8'h60);

    // ---- randomized traffic against a frame-order scoreboard ----
    // Both sources always have a frame queued, so the port must alternate
    // s0, s1, s0, ... frame by frame starting with s0 after reset.
    begin
      beat_t q0[$], q1[$], expq[$];
      beat_t bt, e;
      int exp_err  = 0;
      int fd_cnt   = 0;
      int err_cnt  = 0;
      int drop_cnt = 0;
      int cyc      = 0;
      rst = 1'b0;
      idle_inputs();
      tick();
      rst = 1'b1;
      for (int k = 0; k < 6; k++) begin
        for (int src = 0; src < 2; src++) begin
          int len;
          len = (k == 0) ? L : int'($urandom_range(1, L));
          if (LEN_CHK && len != L) exp_err++;
          for (int i = 0; i < len; i++) begin
            bt.d   = 8'($urandom);
            bt.sop = (i == 0);
            bt.eop = (i == len - 1);
            if (src == 0) q0.push_back(bt);
            else          q1.push_back(bt);
            expq.push_back(bt);
          end
        end
      end
      while (expq.size() > 0 && cyc < 3000) begin
        s0_valid = (q0.size() > 0);
        s1_valid = (q1.size() > 0);
        if (s0_valid) {s0_data, s0_sop, s0_eop} = q0[0];
        else          {s0_data, s0_sop, s0_eop} = '0;
        if (s1_valid) {s1_data, s1_sop, s1_eop} = q1[0];
        else          {s1_data, s1_sop, s1_eop} = '0;
        m_ready = ($urandom_range(0, 3) != 0);
        settle();
        fd_cnt   += int'(frame_done);
        err_cnt  += int'(err_len);
        drop_cnt += int'(drop);
        check("rnd_ready_exclusive", s0_ready & s1_ready, 1'b0);
        if (grant == 2'b01) check("rnd_s0_ready_follows", s0_ready, m_ready);
        if (grant == 2'b10) check("rnd_s1_ready_follows", s1_ready, m_ready);
        if (m_valid && m_ready) begin
          e = expq.pop_front();
          check("rnd_beat", {m_data, m_sop, m_eop}, e);
        end
        if (s0_valid && s0_ready) void'(q0.pop_front());
        if (s1_valid && s1_ready) void'(q1.pop_front());
        cyc++;
        tick();
      end
      check("rnd_all_beats_out", expq.size(), 0);
      idle_inputs();
      for (int i = 0; i < 2; i++) begin
        settle();
        fd_cnt   += int'(frame_done);
        err_cnt  += int'(err_len);
        drop_cnt += int'(drop);
        tick();
      end
      check("rnd_frame_done_count", fd_cnt, 12);
      check("rnd_err_len_count", err_cnt, exp_err);
      check("rnd_drop_count", drop_cnt, 0);
    end

    // ---- frame length: 12-beat frame, then 5-beat frame, on s0 ----
    begin
      int err_seen = 0;
      logic exp_mv;
      s0_valid = 1'b1; s0_sop = 1'b1; s0_data = 8'h70;
      tick();
      for (int b = 0; b < 12; b++) begin
        s0_data = 8'h70 + 8'(b);
        s0_sop  = (b == 0);
        s0_eop  = (b == 11);
        settle();
        err_seen += int'(err_len);
        exp_mv = !LEN_CHK || (b < L);
        check($sformatf("long_m_valid_b%0d", b), m_valid, exp_mv);
        check($sformatf("long_grant_b%0d", b), grant, exp_mv ? 2'b01 : 2'b00);
        check($sformatf("long_s0_ready_b%0d", b), s0_ready, 1'b1);
        check($sformatf("long_drop_b%0d", b), drop, LEN_CHK && (b > L));
        check($sformatf("long_frame_done_b%0d", b), frame_done, LEN_CHK && (b == L));
        if (exp_mv) begin
          check($sformatf("long_beat_b%0d", b), {m_data, m_eop},
                {8'h70 + 8'(b), LEN_CHK ? (b == L - 1) : (b == 11)});
        end
        tick();
      end
      idle_inputs();
      settle();
      err_seen += int'(err_len);
      check("long_tail_drop", drop, LEN_CHK);
      check("long_tail_frame_done", frame_done, !LEN_CHK);
      tick();
      settle();
      err_seen += int'(err_len);
      check("long_err_len_count", err_seen, LEN_CHK ? 1 : 0);

      s0_valid = 1'b1; s0_sop = 1'b1; s0_data = 8'h80;
      tick();
      for (int b = 0; b < 5; b++) begin
        s0_data = 8'h80 + 8'(b);
        s0_sop  = (b == 0);
        s0_eop  = (b == 4);
        settle();
        check($sformatf("short_beat_b%0d", b), {m_valid, m_data, m_eop},
              {1'b1, 8'h80 + 8'(b), b == 4});
        tick();
      end
      idle_inputs();
      settle();
      check("short_err_len", err_len, LEN_CHK);
      check("short_frame_done", frame_done, 1'b1);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
